// File: rtl/voice_bank.sv
// Time-multiplexed oscillator bank: one shared phase/wave/envelope datapath
// visits every voice once per sample_tick and sums the results into mix_out.
module voice_bank #(
  parameter int VOICES    = 4,
  parameter int FREQ_BITS = 16,
  parameter int ACC_BITS  = 24,
  localparam int VB       = $clog2(VOICES),
  localparam int MIX_BITS = 12 + VB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic                cfg_we,
  input  logic [VB-1:0]       cfg_voice,
  input  logic [1:0]          cfg_addr,
  input  logic [15:0]         cfg_data,
  input  logic [VOICES-1:0]   gate,
  output logic [MIX_BITS-1:0] mix_out,
  output logic                mix_valid,
  output logic                busy,
  output logic [VOICES-1:0]   voice_active,
  output logic                overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_e;
  typedef enum logic [2:0] {ENV_IDLE, ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN, ENV_RELEASE} env_e;

  state_e                state_q, state_d;
  logic [VB-1:0]         idx_q, idx_d;

  logic [FREQ_BITS-1:0]  freq_q  [VOICES];
  logic [11:0]           pw_q    [VOICES];
  logic [3:0]            wen_q   [VOICES];
  logic [15:0]           env_q   [VOICES];
  logic [ACC_BITS-1:0]   phase_q [VOICES];
  logic [7:0]            amp_q   [VOICES];
  env_e                  env_st_q[VOICES];
  logic [VOICES-1:0]     gate_q;
  logic [VOICES-1:0]     active_q;

  logic [22:0]           lfsr_q;
  logic signed [11:0]    prod_q;
  logic                  prod_vld_q;
  logic signed [MIX_BITS-1:0] acc_q;
  logic [MIX_BITS-1:0]   mix_q;
  logic                  mix_valid_q;
  logic                  busy_q;
  logic                  overrun_q;

  logic [ACC_BITS-1:0]   phase_d;
  logic [11:0]           p, tri_w, saw_w, pulse_w, noise_w, wave;
  logic [3:0]            wen_cur;
  logic [15:0]           env_cfg;
  logic [8:0]            a_inc, d_inc, r_inc, att_sum;
  logic [7:0]            sus_lvl, amp_cur, amp_d;
  logic                  gate_now, gate_old;
  env_e                  st_edge, st_d;
  logic signed [11:0]    samp;
  logic signed [8:0]     amp_s;
  logic signed [20:0]    prod_full;
  logic signed [11:0]    voice_out;

  // Round sequencer: next state and voice index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_q == VB'(VOICES - 1)) begin
          state_d = ST_FLUSH;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Oscillator and waveform shaping for the voice in flight
  always_comb begin
    phase_d = phase_q[idx_q] + ACC_BITS'(freq_q[idx_q]);
    p       = phase_d[ACC_BITS-1 -: 12];
    saw_w   = p;
    tri_w   = {p[10:0] ^ {11{p[11]}}, 1'b0};
    pulse_w = (p < pw_q[idx_q]) ? 12'hFFF : 12'h000;
    noise_w = lfsr_q[22:11];
    wen_cur = wen_q[idx_q];
    wave    = (wen_cur[0] ? tri_w   : 12'hFFF) &
              (wen_cur[1] ? saw_w   : 12'hFFF) &
              (wen_cur[2] ? pulse_w : 12'hFFF) &
              (wen_cur[3] ? noise_w : 12'hFFF);
    if (wen_cur == 4'h0) begin
      wave = 12'h000;
    end else begin
      wave = wave;
    end
  end

  // Envelope: gate edge handling first, then one ADSR step on the resulting state
  always_comb begin
    env_cfg  = env_q[idx_q];
    a_inc    = {5'd0, env_cfg[15:12]} + 9'd1;
    d_inc    = {5'd0, env_cfg[11:8]} + 9'd1;
    r_inc    = {5'd0, env_cfg[3:0]} + 9'd1;
    sus_lvl  = {env_cfg[7:4], env_cfg[7:4]};
    gate_now = gate[idx_q];
    gate_old = gate_q[idx_q];
    amp_cur  = amp_q[idx_q];
    att_sum  = {1'b0, amp_cur} + a_inc;
    if (gate_now && !gate_old) begin
      st_edge = ENV_ATTACK;
    end else if (!gate_now && gate_old && (env_st_q[idx_q] == ENV_ATTACK ||
                 env_st_q[idx_q] == ENV_DECAY || env_st_q[idx_q] == ENV_SUSTAIN)) begin
      st_edge = ENV_RELEASE;
    end else begin
      st_edge = env_st_q[idx_q];
    end
    st_d  = st_edge;
    amp_d = amp_cur;
    case (st_edge)
      ENV_ATTACK: begin
        if (att_sum >= 9'd255) begin
          amp_d = 8'hFF;
          st_d  = ENV_DECAY;
        end else begin
          amp_d = att_sum[7:0];
        end
      end
      ENV_DECAY: begin
        if ({1'b0, amp_cur} <= ({1'b0, sus_lvl} + d_inc)) begin
          amp_d = sus_lvl;
          st_d  = ENV_SUSTAIN;
        end else begin
          amp_d = amp_cur - d_inc[7:0];
        end
      end
      ENV_SUSTAIN: amp_d = sus_lvl;
      ENV_RELEASE: begin
        if ({1'b0, amp_cur} <= r_inc) begin
          amp_d = 8'h00;
          st_d  = ENV_IDLE;
        end else begin
          amp_d = amp_cur - r_inc[7:0];
        end
      end
      default: amp_d = amp_cur;
    endcase
    // Offset-binary to two's complement is just an MSB flip
    samp      = {~wave[11], wave[10:0]};
    amp_s     = {1'b0, amp_d};
    prod_full = samp * amp_s;
    voice_out = 12'(prod_full >>> 8);
  end

  // Sequencer, mixer pipeline and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      lfsr_q      <= 23'h7FFFFF;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= (state_d != ST_IDLE);
      overrun_q   <= overrun_q | (sample_tick & (state_q != ST_IDLE));
      mix_valid_q <= (state_q == ST_DONE);
      prod_vld_q  <= (state_q == ST_RUN);
      if (state_q == ST_RUN) begin
        prod_q <= voice_out;
        lfsr_q <= {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
      end else begin
        prod_q <= prod_q;
        lfsr_q <= lfsr_q;
      end
      if (state_q == ST_IDLE && sample_tick) begin
        acc_q <= '0;
      end else if (prod_vld_q) begin
        acc_q <= acc_q + MIX_BITS'(prod_q);
      end else begin
        acc_q <= acc_q;
      end
      if (state_q == ST_DONE) begin
        mix_q <= acc_q;
      end else begin
        mix_q <= mix_q;
      end
    end
  end

  // Per-voice oscillator and envelope state, written back when the voice is visited
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VOICES; i++) begin
        phase_q[i]  <= '0;
        amp_q[i]    <= '0;
        env_st_q[i] <= ENV_IDLE;
      end
      gate_q   <= '0;
      active_q <= '0;
    end else if (state_q == ST_RUN) begin
      phase_q[idx_q]  <= phase_d;
      amp_q[idx_q]    <= amp_d;
      env_st_q[idx_q] <= st_d;
      gate_q[idx_q]   <= gate_now;
      active_q[idx_q] <= (st_d != ENV_IDLE);
    end else begin
      gate_q   <= gate_q;
      active_q <= active_q;
    end
  end

  // Configuration register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VOICES; i++) begin
        freq_q[i] <= '0;
        pw_q[i]   <= '0;
        wen_q[i]  <= '0;
        env_q[i]  <= '0;
      end
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    freq_q[cfg_voice] <= FREQ_BITS'(cfg_data);
        2'd1:    pw_q[cfg_voice]   <= cfg_data[11:0];
        2'd2:    wen_q[cfg_voice]  <= cfg_data[3:0];
        2'd3:    env_q[cfg_voice]  <= cfg_data;
        default: env_q[cfg_voice]  <= env_q[cfg_voice];
      endcase
    end else begin
      freq_q <= freq_q;
    end
  end

  assign mix_out      = mix_q;
  assign mix_valid    = mix_valid_q;
  assign busy         = busy_q;
  assign voice_active = active_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/voice_bank.md
VOICE_BANK -- requirements
Module: voice_bank

Interface
REQ-001 SHALL have parameter VOICES, default 4, voice count; power of two, 2..16.
REQ-002 SHALL have parameter FREQ_BITS, default 16, per-voice frequency word width.
REQ-003 SHALL have parameter ACC_BITS, default 24, phase accumulator width; ACC_BITS >= FREQ_BITS and ACC_BITS >= 12.
REQ-004 SHALL derive VB = clog2(VOICES) and MIX_BITS = 12+VB.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 SHALL have port sample_tick  input  1  starts one processing round.
REQ-008 SHALL have port cfg_we  input  1  config write strobe.
REQ-009 SHALL have port cfg_voice  input  VB  target voice of write.
REQ-010 SHALL have port cfg_addr  input  2  register select: 0 freq[FREQ_BITS-1:0]; 1 pulse width[11:0]; 2 waveform enables[3:0] = {noise,pulse,saw,tri}; 3 envelope {A[15:12],D[11:8],S[7:4],R[3:0]}.
REQ-011 SHALL have port cfg_data  input  16  write data; unused high bits ignored.
REQ-012 SHALL have port gate  input  VOICES  per-voice envelope gate.
REQ-013 SHALL have port mix_out  output  MIX_BITS  signed sum of all voice samples.
REQ-014 SHALL have port mix_valid  output  1  one-cycle pulse when mix_out updates.
REQ-015 SHALL have port busy  output  1  high while a round is in progress.
REQ-016 SHALL have port voice_active  output  VOICES  bit i high when voice i envelope is not IDLE.
REQ-017 SHALL have port overrun  output  1  sticky: a sample_tick arrived while busy.

Function
REQ-018 SHALL sequence with FSM IDLE -> RUN -> FLUSH -> DONE -> IDLE; one shared datapath, one voice per RUN cycle.
REQ-019 SHALL enter RUN on the edge sampling sample_tick=1 in IDLE; RUN lasts VOICES cycles, processing voices 0..VOICES-1 in order; FLUSH accumulates the last product; DONE loads mix_out and asserts mix_valid; mix_valid is high exactly VOICES+2 cycles after the sampling edge.
REQ-020 SHALL hold busy=1 in RUN, FLUSH and DONE; a sample_tick while busy is ignored and sets overrun.
REQ-021 SHALL apply a config write on its clock edge; a voice processed in the same cycle uses the old value.
REQ-022 SHALL, per processed voice, update phase = (phase + freq zero-extended) mod 2^ACC_BITS; p = new phase[ACC_BITS-1:ACC_BITS-12].
REQ-023 SHALL form saw = p; tri = {p[10:0] XOR {11{p[11]}}, 0}; pulse = 12'hFFF if p < pulse_width else 0; noise = bits [22:11] of a shared 23-bit LFSR (taps 23,18) advanced once per RUN cycle.
REQ-024 SHALL combine enabled waveforms by bitwise AND; no enable -> wave = 0.
REQ-025 SHALL compute signed sample s = wave - 2048 (12-bit signed), voice out = (s * amp) >>> 8, amp 8-bit unsigned, result 12-bit signed; the multiply is registered one stage, accumulation one cycle after.
REQ-026 SHALL sum voice outputs into a MIX_BITS signed accumulator cleared at round start; no saturation.
REQ-027 SHALL keep per-voice envelope state IDLE/ATTACK/DECAY/SUSTAIN/RELEASE and 8-bit amp, updated only when that voice is processed.
REQ-028 SHALL detect gate edges against a per-voice gate copy stored at processing: rising -> ATTACK from any state, amp retained; falling -> RELEASE from ATTACK/DECAY/SUSTAIN.
REQ-029 SHALL step: ATTACK amp += A+1, saturate 255 -> DECAY; DECAY amp -= D+1, clamp at L = S*17 -> SUSTAIN; SUSTAIN holds L; RELEASE amp -= R+1, clamp 0 -> IDLE.
REQ-030 SHALL use current amp after this round's envelope update in REQ-025.

Reset
REQ-031 SHALL, on rst=0, immediately clear phases, config registers, gate copies, amp, accumulator, mix_out, mix_valid, busy, overrun; envelopes IDLE; FSM IDLE; LFSR = 23'h7FFFFF.
REQ-032 SHALL abort a round on reset mid-RUN with no mix_valid; first tick after release starts a fresh round.

Verification
REQ-033 SHALL cover: reset, voice0 freq=16'h1000 saw only, gate0=1, A=F S=F, 20 ticks -> amp reaches 255 by round 16, mix_valid each round at tick+VOICES+2.
REQ-034 SHALL cover: all voices waveform 0 -> mix_out = 0 every round; each active voice contributes 0 only when amp = 0.
REQ-035 SHALL cover: gate0 drop in SUSTAIN, R=0 -> amp decrements 1 per round, IDLE and voice_active[0]=0 after amp hits 0.
REQ-036 SHALL cover: sample_tick asserted two consecutive cycles -> second ignored, overrun=1 until reset.
REQ-037 SHALL cover: freq=16'hFFFF, ACC_BITS=24 phase wrap -> saw output drops from near 12'hFFF to near 0 with no glitch in mix_valid timing.
REQ-038 SHALL cover: rst low during RUN -> outputs 0 immediately, no mix_valid; next tick yields full round.
